draw_multi: RTL and testbench



---
 rtl/draw_multi.sv | 158 +++++++++++++++
 tb/tb_draw_multi.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_multi.sv
// draw_multi: animates N_BOX bouncing boxes inside a rectangular playfield on the
// 640x480 VGA path and emits a registered 3-3-2 RGB pixel plus per-frame events.
module draw_multi #(
  parameter int unsigned N_BOX     = 2,
  parameter int unsigned BOX_W     = 36,
  parameter int unsigned BOX_H     = 36,
  parameter int unsigned LEFT      = 144,
  parameter int unsigned RIGHT     = 784,
  parameter int unsigned TOP       = 36,
  parameter int unsigned BOTTOM    = 500,
  parameter logic [7:0]  FIELD_RGB = 8'hCE,
  parameter logic [7:0]  BOX_RGB   = 8'hA5
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [2:0] step,
  input  logic       pause,
  output logic [7:0] rgb,
  output logic       frame_tick,
  output logic       bounce,
  output logic       collide
);

  localparam int unsigned PW  = 10;  // position width
  localparam int unsigned CW  = 11;  // compare width, one bit of headroom
  localparam int unsigned NW  = 3;   // coverage count, holds up to 4 boxes
  localparam int unsigned GAP = 8;   // reset spacing between neighbouring boxes

  logic [N_BOX-1:0][PW-1:0] x_q, x_d, y_q, y_d;
  logic [N_BOX-1:0]         dx_q, dx_d, dy_q, dy_d;
  logic [7:0]               rgb_q, rgb_d;
  logic                     frame_tick_q, frame_tick_d;
  logic                     bounce_q, bounce_d;
  logic                     collide_q, collide_d;
  logic                     overlap_seen_q, overlap_seen_d;

  logic                     strobe_c, move_c, hit_c, overlap_c, box_hit_c;
  logic [CW-1:0]            step_c, h_c, v_c;
  logic [NW-1:0]            cover_cnt_c;

  assign strobe_c = (h_count == PW'(1)) && (v_count == PW'(1));
  assign move_c   = strobe_c && !pause && (step != 3'd0);
  assign step_c   = CW'(step);
  assign h_c      = CW'(h_count);
  assign v_c      = CW'(v_count);

  // Per-box motion: advance by step, clamp to the wall and reverse on reaching it
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    hit_c = 1'b0;
    if (move_c) begin
      for (int unsigned i = 0; i < N_BOX; i++) begin
        if (!dx_q[i]) begin
          if (CW'(x_q[i]) + step_c + CW'(BOX_W) >= CW'(RIGHT)) begin
            x_d[i]  = PW'(RIGHT - BOX_W);
            dx_d[i] = 1'b1;
            hit_c   = 1'b1;
          end else begin
            x_d[i] = x_q[i] + PW'(step);
          end
        end else begin
          if (CW'(x_q[i]) <= CW'(LEFT) + step_c) begin
            x_d[i]  = PW'(LEFT);
            dx_d[i] = 1'b0;
            hit_c   = 1'b1;
          end else begin
            x_d[i] = x_q[i] - PW'(step);
          end
        end
        if (!dy_q[i]) begin
          if (CW'(y_q[i]) + step_c + CW'(BOX_H) >= CW'(BOTTOM)) begin
            y_d[i]  = PW'(BOTTOM - BOX_H);
            dy_d[i] = 1'b1;
            hit_c   = 1'b1;
          end else begin
            y_d[i] = y_q[i] + PW'(step);
          end
        end else begin
          if (CW'(y_q[i]) <= CW'(TOP) + step_c) begin
            y_d[i]  = PW'(TOP);
            dy_d[i] = 1'b0;
            hit_c   = 1'b1;
          end else begin
            y_d[i] = y_q[i] - PW'(step);
          end
        end
      end
    end
  end

  // Pixel colour (lowest-index box wins) and multi-box coverage of the current pixel
  always_comb begin
    box_hit_c   = 1'b0;
    cover_cnt_c = '0;
    if (h_c >= CW'(LEFT) && h_c < CW'(RIGHT) && v_c >= CW'(TOP) && v_c < CW'(BOTTOM)) begin
      rgb_d = FIELD_RGB;
    end else begin
      rgb_d = 8'h00;
    end
    for (int unsigned i = 0; i < N_BOX; i++) begin
      if (h_c >= CW'(x_q[i]) && h_c < CW'(x_q[i]) + CW'(BOX_W) &&
          v_c >= CW'(y_q[i]) && v_c < CW'(y_q[i]) + CW'(BOX_H)) begin
        if (!box_hit_c) begin
          rgb_d = BOX_RGB + 8'(17 * i);
        end
        box_hit_c   = 1'b1;
        cover_cnt_c = cover_cnt_c + NW'(1);
      end
    end
    overlap_c = (cover_cnt_c >= NW'(2));
  end

  // Frame events: tick and bounce pulse after the strobe; collide reports the closing frame
  always_comb begin
    frame_tick_d   = strobe_c;
    bounce_d       = move_c && hit_c;
    collide_d      = strobe_c ? overlap_seen_q : collide_q;
    overlap_seen_d = strobe_c ? overlap_c : (overlap_seen_q || overlap_c);
  end

  // State registers; boxes restart staggered diagonally
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_BOX; i++) begin
        x_q[i]  <= PW'(LEFT + i * (BOX_W + GAP));
        y_q[i]  <= PW'(TOP + i * (BOX_H + GAP));
        dx_q[i] <= 1'(i & 1);
        dy_q[i] <= 1'b0;
      end
      rgb_q          <= 8'h00;
      frame_tick_q   <= 1'b0;
      bounce_q       <= 1'b0;
      collide_q      <= 1'b0;
      overlap_seen_q <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      rgb_q          <= rgb_d;
      frame_tick_q   <= frame_tick_d;
      bounce_q       <= bounce_d;
      collide_q      <= collide_d;
      overlap_seen_q <= overlap_seen_d;
    end
  end

  assign rgb        = rgb_q;
  assign frame_tick = frame_tick_q;
  assign bounce     = bounce_q;
  assign collide    = collide_q;

endmodule

// File: tb/tb_draw_multi.sv
// tb_draw_multi: drives pixel coordinates directly (short synthetic frames) and checks
// draw_multi against constant tables and a behavioural box model.
module tb_draw_multi;

  localparam int NB = 2;
  localparam int BW = 36;
  localparam int BH = 36;
  localparam int LF = 144;
  localparam int RT = 784;
  localparam int TP = 36;
  localparam int BT = 500;

  logic       clk_25 = 1'b0;
  logic       rst_n;
  logic [9:0] h_count, v_count;
  logic [2:0] step;
  logic       pause;
  logic [7:0] rgb;
  logic       frame_tick, bounce, collide;

  always #20 clk_25 = ~clk_25;

  draw_multi dut (
    .clk_25    (clk_25),
    .rst_n     (rst_n),
    .h_count   (h_count),
    .v_count   (v_count),
    .step      (step),
    .pause     (pause),
    .rgb       (rgb),
    .frame_tick(frame_tick),
    .bounce    (bounce),
    .collide   (collide)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model of the boxes and the frame flags
  int mx[NB];
  int my[NB];
  bit mdx[NB];
  bit mdy[NB];
  bit m_seen, m_col;

  typedef struct {
    int h;
    int v;
    int rgb;
  } vec_t;

  vec_t rst_tbl[14];
  vec_t mov_tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i]  = LF + i * (BW + 8);
      my[i]  = TP + i * (BH + 8);
      mdx[i] = (i % 2) == 1;
      mdy[i] = 1'b0;
    end
    m_seen = 1'b0;
    m_col  = 1'b0;
  endfunction

  function automatic bit m_covers(int i, int h, int v);
    return h >= mx[i] && h < mx[i] + BW && v >= my[i] && v < my[i] + BH;
  endfunction

  function automatic int m_colour(int h, int v);
    for (int i = 0; i < NB; i++)
      if (m_covers(i, h, v)) return (165 + 17 * i) % 256;
    if (h >= LF && h < RT && v >= TP && v < BT) return 206;
    return 0;
  endfunction

  function automatic int m_count(int h, int v);
    int n = 0;
    for (int i = 0; i < NB; i++)
      if (m_covers(i, h, v)) n++;
    return n;
  endfunction

  // Move one axis coordinate; a target at or beyond a wall snaps to the wall and reverses.
  function automatic bit m_axis(inout int p, inout bit dir, input int s, input int lo, input int hi, input int sz);
    int t;
    if (!dir) begin
      t = p + s;
      if (t + sz >= hi) begin p = hi - sz; dir = 1'b1; return 1'b1; end
    end else begin
      t = p - s;
      if (t <= lo) begin p = lo; dir = 1'b0; return 1'b1; end
    end
    p = t;
    return 1'b0;
  endfunction

  function automatic bit m_move(int s);
    bit b = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (m_axis(mx[i], mdx[i], s, LF, RT, BW)) b = 1'b1;
      if (m_axis(my[i], mdy[i], s, TP, BT, BH)) b = 1'b1;
    end
    return b;
  endfunction

  task automatic find_overlap(output bit f, output int ox, output int oy);
    f = 1'b0; ox = 0; oy = 0;
    for (int i = 0; i < NB; i++)
      for (int j = i + 1; j < NB; j++)
        if (!f && mx[i] < mx[j] + BW && mx[j] < mx[i] + BW && my[i] < my[j] + BH && my[j] < my[i] + BH) begin
          f  = 1'b1;
          ox = (mx[i] > mx[j]) ? mx[i] : mx[j];
          oy = (my[i] > my[j]) ? my[i] : my[j];
        end
  endtask

  // Present one pixel for one clock and check all outputs against the model
  task automatic pix(input int h, input int v);
    int e_rgb, cnt;
    bit e_ft, e_bn;
    h_count = 10'(h);
    v_count = 10'(v);
    e_rgb = m_colour(h, v);
    cnt   = m_count(h, v);
    e_ft  = 1'b0;
    e_bn  = 1'b0;
    if (h == 1 && v == 1) begin
      e_ft   = 1'b1;
      m_col  = m_seen;
      m_seen = (cnt >= 2);
      if (!pause && step != 3'd0) e_bn = m_move(int'(step));
    end else if (cnt >= 2) begin
      m_seen = 1'b1;
    end
    @(posedge clk_25);
    #1;
    chk($sformatf("rgb@%0d,%0d", h, v), int'(rgb), e_rgb);
    chk("frame_tick", int'(frame_tick), int'(e_ft));
    chk("bounce", int'(bounce), int'(e_bn));
    chk("collide", int'(collide), int'(m_col));
  endtask

  task automatic frame();
    pix(1, 1);
    pix(0, 0);
  endtask

  task automatic probe_boxes();
    for (int i = 0; i < NB; i++) begin
      pix(mx[i], my[i]);
      pix(mx[i] + BW - 1, my[i] + BH - 1);
      pix(mx[i] - 1, my[i]);
      pix(mx[i] + BW, my[i] + BH - 1);
    end
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int ox, oy, ft_cnt, sx, sy;

    rst_tbl[0]  = '{10, 10, 8'h00};
    rst_tbl[1]  = '{600, 400, 8'hCE};
    rst_tbl[2]  = '{144, 36, 8'hA5};
    rst_tbl[3]  = '{179, 71, 8'hA5};
    rst_tbl[4]  = '{180, 71, 8'hCE};
    rst_tbl[5]  = '{143, 36, 8'h00};
    rst_tbl[6]  = '{144, 35, 8'h00};
    rst_tbl[7]  = '{188, 80, 8'hB6};
    rst_tbl[8]  = '{223, 115, 8'hB6};
    rst_tbl[9]  = '{224, 115, 8'hCE};
    rst_tbl[10] = '{783, 499, 8'hCE};
    rst_tbl[11] = '{784, 499, 8'h00};
    rst_tbl[12] = '{783, 500, 8'h00};
    rst_tbl[13] = '{200, 100, 8'hB6};

    mov_tbl[0] = '{144, 36, 8'hCE};
    mov_tbl[1] = '{145, 37, 8'hA5};
    mov_tbl[2] = '{180, 72, 8'hA5};
    mov_tbl[3] = '{181, 72, 8'hCE};
    mov_tbl[4] = '{186, 81, 8'hCE};
    mov_tbl[5] = '{187, 81, 8'hB6};
    mov_tbl[6] = '{222, 116, 8'hB6};
    mov_tbl[7] = '{223, 116, 8'hCE};
    mov_tbl[8] = '{145, 36, 8'hCE};

    rst_n = 1'b1; h_count = '0; v_count = '0; step = 3'd1; pause = 1'b0;
    m_reset();
    #3 rst_n = 1'b0;
    #2;
    chk("reset rgb", int'(rgb), 0);
    chk("reset frame_tick", int'(frame_tick), 0);
    chk("reset bounce", int'(bounce), 0);
    chk("reset collide", int'(collide), 0);
    repeat (2) @(posedge clk_25);
    #1 rst_n = 1'b1;

    // Reset positions, colours and playfield edges
    foreach (rst_tbl[k]) begin
      pix(rst_tbl[k].h, rst_tbl[k].v);
      chk($sformatf("rst_tbl[%0d]", k), int'(rgb), rst_tbl[k].rgb);
    end

    // One strobe with step=1
    pix(1, 1);
    chk("first strobe frame_tick", int'(frame_tick), 1);
    chk("first strobe bounce", int'(bounce), 0);
    pix(0, 0);
    chk("tick one cycle", int'(frame_tick), 0);
    foreach (mov_tbl[k]) begin
      pix(mov_tbl[k].h, mov_tbl[k].v);
      chk($sformatf("mov_tbl[%0d]", k), int'(rgb), mov_tbl[k].rgb);
    end

    // Pause holds everything; frame_tick still pulses
    sx = mx[0]; sy = my[0];
    pause = 1'b1; step = 3'd3; ft_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      pix(1, 1);
      if (frame_tick) ft_cnt++;
      chk("pause bounce", int'(bounce), 0);
      pix(0, 0);
      if (frame_tick) ft_cnt++;
    end
    chk("pause tick count", ft_cnt, 3);
    pix(sx, sy);
    chk("pause hold box0", int'(rgb), 8'hA5);
    pix(sx - 1, sy);
    chk("pause hold left of box0", int'(rgb), 8'hCE);
    probe_boxes();

    // step=0 behaves like pause
    pause = 1'b0; step = 3'd0; ft_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      pix(1, 1);
      if (frame_tick) ft_cnt++;
      chk("step0 bounce", int'(bounce), 0);
      pix(0, 0);
      if (frame_tick) ft_cnt++;
    end
    chk("step0 tick count", ft_cnt, 3);
    pix(sx, sy);
    chk("step0 hold box0", int'(rgb), 8'hA5);
    probe_boxes();

    // Right wall: box0 at 747 moving right, step 1
    step = 3'd1; found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (mx[0] == 747 && !mdx[0]) found = 1'b1;
      else frame();
    end
    chk("reach x=747", int'(found), 1);
    pix(1, 1);
    chk("right wall bounce", int'(bounce), 1);
    pix(783, my[0]);
    chk("box0 at 748 right edge", int'(rgb), 8'hA5);
    pix(1, 1);
    pix(747, my[0]);
    chk("box0 back at 747", int'(rgb), 8'hA5);

    // Left wall: box0 at 146 moving left, step 4
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (mx[0] == 146 && mdx[0]) found = 1'b1;
      else frame();
    end
    chk("reach x=146", int'(found), 1);
    step = 3'd4;
    pix(1, 1);
    chk("left wall bounce", int'(bounce), 1);
    pix(144, my[0]);
    chk("box0 clamped to 144", int'(rgb), 8'hA5);
    pix(143, my[0]);
    chk("left of playfield", int'(rgb), 8'h00);
    pix(1, 1);
    pix(148, my[0]);
    chk("box0 moved right", int'(rgb), 8'hA5);
    probe_boxes();

    // Randomised frames, step and pause changing mid-frame
    for (int f = 0; f < 150; f++) begin
      pause = ($urandom_range(7, 0) == 0);
      for (int k = 0; k < 10; k++) begin
        step = 3'($urandom_range(7, 0));
        if ($urandom_range(1, 0) == 0) begin
          pix($urandom_range(799, 0), $urandom_range(524, 0));
        end else begin
          int b;
          b = $urandom_range(NB - 1, 0);
          pix(mx[b] - 1 + $urandom_range(BW + 1, 0), my[b] - 1 + $urandom_range(BH + 1, 0));
        end
      end
      find_overlap(found, ox, oy);
      if (found) pix(ox, oy);
      pix(1, 1);
    end

    // Drive the boxes into each other, then freeze them
    pause = 1'b0; found = 1'b0;
    for (int k = 0; k < 20000 && !found; k++) begin
      find_overlap(found, ox, oy);
      if (!found) begin
        step = 3'($urandom_range(7, 1));
        frame();
      end
    end
    chk("overlap reached", int'(found), 1);
    if (found) begin
      step = 3'd0;
      pix(1, 1);
      pix(0, 0);
      pix(ox, oy);
      chk("overlap pixel colour", int'(rgb), 8'hA5);
      pix(1, 1);
      chk("collide set", int'(collide), 1);
      pix(10, 10);
      chk("outside colour", int'(rgb), 8'h00);
      pix(1, 1);
      chk("collide cleared", int'(collide), 0);
      pix(ox, oy);
      pix(1, 1);
      chk("collide set again", int'(collide), 1);
      pix(ox, oy);
      #5 rst_n = 1'b0;
      #1;
      chk("async reset rgb", int'(rgb), 0);
      chk("async reset collide", int'(collide), 0);
      chk("async reset frame_tick", int'(frame_tick), 0);
      chk("async reset bounce", int'(bounce), 0);
      m_reset();
      @(posedge clk_25);
      #1 rst_n = 1'b1;
      pix(144, 36);
      chk("post reset box0", int'(rgb), 8'hA5);
      pix(188, 80);
      chk("post reset box1", int'(rgb), 8'hB6);
      step = 3'd1;
      pix(1, 1);
      chk("post reset collide", int'(collide), 0);
      probe_boxes();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
